sipo_frame_decoder: RTL
=======================

Name: sipo_frame_decoder

Overview:
- Receive-side counterpart of the serial message encoder.
- Accepts the LSB-first serial bit stream that the PISO encoder produces.
- Locates frame alignment with a sync word, reassembles payload bytes, and presents each byte with a one-cycle valid strobe.
- Keeps lock across frames with a flywheel and drops lock after repeated sync misses.

Parameters:
- DATA_WIDTH, 8: bits per word.
- SYNC_WORD, 8'hA5: frame alignment word, DATA_WIDTH bits, sent LSB first.
- PAYLOAD_WORDS, 4: data words between consecutive sync words.
- MAX_MISSES, 3: consecutive bad sync words that force a return to HUNT.

Ports:
- clock  in  1  rising-edge system clock.
- resetN  in  1  asynchronous active-low reset.
- serialIn  in  1  serial data bit.
- serialValid  in  1  qualifies serialIn. Bits with serialValid=0 are ignored, which covers the encoder's idle load cycle.
- message  out  DATA_WIDTH  last completed payload word. Bit 0 is the first bit received.
- messageValid  out  1  one-cycle strobe: message holds a new word.
- locked  out  1  high in SYNC_CHECK and DATA states.
- syncError  out  1  one-cycle strobe on each bad sync word while locked.
- lockLost  out  1  one-cycle strobe when MAX_MISSES is reached.

Behaviour:
- Reset (resetN=0, async): state=HUNT; shift register, bit counter, word counter and miss counter all 0. Outputs message=0, messageValid=0, locked=0, syncError=0, lockLost=0.
- Shift register: on each valid bit, shiftReg <= {serialIn, shiftReg[DATA_WIDTH-1:1]}. After DATA_WIDTH bits, the first bit received sits in bit 0.
- Cycles with serialValid=0: no state, counter or shift change; all strobes 0.
- HUNT: slide one valid bit at a time. When the post-shift value equals SYNC_WORD, go to DATA with bitCnt=0, wordCnt=0, missCnt=0. No bit counting in HUNT.
- DATA: bitCnt counts valid bits from 0 to DATA_WIDTH-1.
  - The edge that samples bit DATA_WIDTH-1 registers message=post-shift value and sets messageValid=1 for that one cycle.
  - Latency is therefore 1 cycle after the last bit is presented.
  - Then bitCnt wraps to 0 and wordCnt increments.
  - When wordCnt reaches PAYLOAD_WORDS, go to SYNC_CHECK.
- SYNC_CHECK: collect DATA_WIDTH valid bits, then compare.
  - Match: missCnt=0, go to DATA.
  - Mismatch with missCnt+1 < MAX_MISSES: syncError=1, missCnt++, go to DATA (flywheel: frame timing kept).
  - Mismatch with missCnt+1 == MAX_MISSES: syncError=1, lockLost=1 (same cycle), go to HUNT, clear shift register and counters.
- messageValid is never asserted in HUNT or SYNC_CHECK. message holds its last value until the next strobe.
- Counter widths: bitCnt is clog2(DATA_WIDTH) bits, wordCnt is clog2(PAYLOAD_WORDS+1) bits, missCnt is clog2(MAX_MISSES+1) bits. None may wrap past its terminal value.
- Reset asserted mid-word: partial word discarded, no strobe. After release the block re-enters HUNT and needs a full SYNC_WORD before any output.
- The HUNT match ignores payload-aliasing concerns: the first match locks. False locks are recovered only via the miss mechanism.

Decomposition:
- Shared package: state enum (HUNT, DATA, SYNC_CHECK), default SYNC_WORD, DATA_WIDTH, and a clog2 function. The encoder uses the same package constants.
- One natural sub-module: sipo_shift_reg.
  - Parameterized DATA_WIDTH.
  - Ports: clock, resetN, shiftEn, clear, serialIn, parallelOut.
  - Mirror of the encoder's PISO.
- The FSM and counters stay in the top module.

Test Plan:
- Reset mid-word.
  - Stimulus: stream A5 then 5 payload bits, assert resetN=0 for 1 cycle, release, send 12,34,56,78 with no sync.
  - Required: no messageValid, locked=0 throughout.
- Basic lock.
  - Stimulus: after reset send 0xFF filler, then A5, 12, 34, 56, 78, A5 (LSB first, serialValid=1 continuously).
  - Required: locked rises on the edge sampling A5's last bit. Exactly 4 messageValid strobes carrying 0x12, 0x34, 0x56, 0x78, each 1 cycle after the word's 8th bit. No syncError.
- Gapped stream.
  - Stimulus: same stream as basic lock, with serialValid=0 for one cycle after every 8 valid bits (encoder cadence).
  - Required: identical words to basic lock. The strobe is delayed only by the inserted gaps.
- Flywheel.
  - Stimulus: locked stream whose second sync word is 0x5A.
  - Required: syncError pulses once, locked stays 1. The following payload words are still output correctly.
- Loss of lock.
  - Stimulus: 3 consecutive corrupted sync words (0x00).
  - Required: syncError on each. lockLost and the 3rd syncError occur in the same cycle, locked falls, then no messageValid until a new A5.
- Relock.
  - Stimulus: after loss of lock, send A5, then payload 0xA5, 0x01, 0x02, 0x03.
  - Required: relock on the sync. A payload value equal to SYNC_WORD is output normally: strobes give 0xA5, 0x01, 0x02, 0x03.

Source files
------------

// File: rtl/sipo_frame_decoder_pkg.sv
// Shared constants and types for the serial frame encoder/decoder pair.
package sipo_frame_decoder_pkg;

    typedef enum logic [1:0] {
        HUNT,
        DATA,
        SYNC_CHECK
    } state_t;

    localparam int         DEF_DATA_WIDTH    = 8;
    localparam logic [7:0] DEF_SYNC_WORD     = 8'hA5;
    localparam int         DEF_PAYLOAD_WORDS = 4;
    localparam int         DEF_MAX_MISSES    = 3;

    // Bits needed to hold values 0..n-1; never less than 1.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sipo_frame_decoder_if.sv
// Serial-in / word-out bundle between the bit source and the frame decoder.
interface sipo_frame_decoder_if
    import sipo_frame_decoder_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  serialIn;
    logic                  serialValid;
    logic [DATA_WIDTH-1:0] message;
    logic                  messageValid;
    logic                  locked;
    logic                  syncError;
    logic                  lockLost;

    modport master (
        output serialIn, serialValid,
        input  message, messageValid, locked, syncError, lockLost
    );

    modport slave (
        input  serialIn, serialValid,
        output message, messageValid, locked, syncError, lockLost
    );
endinterface

// File: rtl/sipo_frame_decoder_shift_reg.sv
// LSB-first serial-in parallel-out register; the first bit received ends up in bit 0.
module sipo_shift_reg
    import sipo_frame_decoder_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
)(
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  shiftEn,
    input  logic                  clear,
    input  logic                  serialIn,
    output logic [DATA_WIDTH-1:0] parallelOut
);
    logic [DATA_WIDTH-1:0] r_shift;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_shift <= '0;
        end else if (clear) begin
            r_shift <= '0;
        end else if (shiftEn) begin
            r_shift <= {serialIn, r_shift[DATA_WIDTH-1:1]};
        end
    end

    assign parallelOut = r_shift;
endmodule

// File: rtl/sipo_frame_decoder.sv
// Frame decoder: hunts for the sync word, emits payload words, and tracks lock with a miss flywheel.
module sipo_frame_decoder
    import sipo_frame_decoder_pkg::*;
#(
    parameter int                    DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] SYNC_WORD     = DATA_WIDTH'(DEF_SYNC_WORD),
    parameter int                    PAYLOAD_WORDS = DEF_PAYLOAD_WORDS,
    parameter int                    MAX_MISSES    = DEF_MAX_MISSES
)(
    input  logic               clock,
    input  logic               resetN,
    sipo_frame_decoder_if.slave bus
);
    localparam int BW = clog2(DATA_WIDTH);
    localparam int WW = clog2(PAYLOAD_WORDS + 1);
    localparam int MW = clog2(MAX_MISSES + 1);

    localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_WIDTH - 1);
    localparam logic [WW-1:0] WORD_LAST  = WW'(PAYLOAD_WORDS - 1);
    localparam logic [WW-1:0] WORD_FULL  = WW'(PAYLOAD_WORDS);
    localparam logic [MW-1:0] MISS_LAST  = MW'(MAX_MISSES - 1);

    state_t                r_state;
    logic [BW-1:0]         r_bitCnt;
    logic [WW-1:0]         r_wordCnt;
    logic [MW-1:0]         r_missCnt;
    logic [DATA_WIDTH-1:0] r_message;
    logic                  r_messageValid;
    logic                  r_locked;
    logic                  r_syncError;
    logic                  r_lockLost;

    logic [DATA_WIDTH-1:0] w_shiftOut;
    logic [DATA_WIDTH-1:0] w_postShift;
    logic                  w_wordDone;
    logic                  w_syncMatch;
    logic                  w_lastMiss;
    logic                  w_clear;

    sipo_shift_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shift (
        .clock       (clock),
        .resetN      (resetN),
        .shiftEn     (bus.serialValid),
        .clear       (w_clear),
        .serialIn    (bus.serialIn),
        .parallelOut (w_shiftOut)
    );

    // Decisions are made on the value the shift register will hold after this bit.
    assign w_postShift = {bus.serialIn, w_shiftOut[DATA_WIDTH-1:1]};
    assign w_wordDone  = (r_bitCnt == BIT_LAST);
    assign w_syncMatch = (w_postShift == SYNC_WORD);
    assign w_lastMiss  = (r_missCnt == MISS_LAST);
    assign w_clear     = bus.serialValid && (r_state == SYNC_CHECK) && w_wordDone &&
                         !w_syncMatch && w_lastMiss;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state        <= HUNT;
            r_bitCnt       <= '0;
            r_wordCnt      <= '0;
            r_missCnt      <= '0;
            r_message      <= '0;
            r_messageValid <= 1'b0;
            r_locked       <= 1'b0;
            r_syncError    <= 1'b0;
            r_lockLost     <= 1'b0;
        end else begin
            r_messageValid <= 1'b0;
            r_syncError    <= 1'b0;
            r_lockLost     <= 1'b0;
            if (bus.serialValid) begin
                case (r_state)
                    HUNT: begin
                        if (w_syncMatch) begin
                            r_state   <= DATA;
                            r_bitCnt  <= '0;
                            r_wordCnt <= '0;
                            r_missCnt <= '0;
                            r_locked  <= 1'b1;
                        end
                    end
                    DATA: begin
                        if (w_wordDone) begin
                            r_message      <= w_postShift;
                            r_messageValid <= 1'b1;
                            r_bitCnt       <= '0;
                            if (r_wordCnt == WORD_LAST) begin
                                r_wordCnt <= WORD_FULL;
                                r_state   <= SYNC_CHECK;
                            end else begin
                                r_wordCnt <= r_wordCnt + 1'b1;
                            end
                        end else begin
                            r_bitCnt <= r_bitCnt + 1'b1;
                        end
                    end
                    SYNC_CHECK: begin
                        if (w_wordDone) begin
                            r_bitCnt  <= '0;
                            r_wordCnt <= '0;
                            if (w_syncMatch) begin
                                r_missCnt <= '0;
                                r_state   <= DATA;
                            end else if (w_lastMiss) begin
                                r_syncError <= 1'b1;
                                r_lockLost  <= 1'b1;
                                r_missCnt   <= '0;
                                r_locked    <= 1'b0;
                                r_state     <= HUNT;
                            end else begin
                                // Flywheel: keep frame timing through an isolated bad sync.
                                r_syncError <= 1'b1;
                                r_missCnt   <= r_missCnt + 1'b1;
                                r_state     <= DATA;
                            end
                        end else begin
                            r_bitCnt <= r_bitCnt + 1'b1;
                        end
                    end
                    default: r_state <= HUNT;
                endcase
            end
        end
    end

    assign bus.message      = r_message;
    assign bus.messageValid = r_messageValid;
    assign bus.locked       = r_locked;
    assign bus.syncError    = r_syncError;
    assign bus.lockLost     = r_lockLost;
endmodule
